// File: rtl/sha3_msg_ctrl.sv
// Message sequencer for a 64-bit-word SHA3-512 core: clears the core, forwards host words one cycle
// after handshake (stalls on core buffer-full), then captures the digest or flags a timeout.
module sha3_msg_ctrl #(
  parameter int DATA_W   = 64,
  parameter int DIGEST_W = 512,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 4096
) (
  input  logic                ICLK,
  input  logic                IRST,
  input  logic                ISTART,
  input  logic [DATA_W-1:0]   IWDATA,
  input  logic                IWVALID,
  input  logic                IWLAST,
  input  logic [2:0]          IWBYTES,
  output logic                OWREADY,
  output logic                OBUSY,
  output logic                ODONE,
  output logic                OERR,
  output logic [DIGEST_W-1:0] ODIGEST,
  output logic [CNT_W-1:0]    OWORD_CNT,
  output logic                OK_RST,
  output logic [DATA_W-1:0]   OK_DATA,
  output logic                OK_READY,
  output logic                OK_LAST,
  output logic [2:0]          OK_BYTE_NUM,
  input  logic                IK_BUFFER_FULL,
  input  logic [DIGEST_W-1:0] IK_DATA,
  input  logic                IK_READY
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CLR, ABSORB, WAIT} state_t;

  state_t           state, state_nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             xfer;
  logic             tmo_hit;

  assign xfer    = (state == ABSORB) && IWVALID && !IK_BUFFER_FULL;
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge ICLK) begin
    if (!IRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    OWREADY   = 1'b0;
    OK_RST    = 1'b0;
    OBUSY     = (state != IDLE);
    case (state)
      IDLE:   if (ISTART) state_nxt = CLR;
      CLR: begin
        OK_RST    = 1'b1;
        state_nxt = ABSORB;
      end
      ABSORB: begin
        OWREADY = !IK_BUFFER_FULL;
        if (xfer && IWLAST) state_nxt = WAIT;
      end
      WAIT:   if (IK_READY || tmo_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ICLK) begin
    if (!IRST) begin
      ODONE       <= 1'b0;
      OERR        <= 1'b0;
      ODIGEST     <= '0;
      OWORD_CNT   <= '0;
      OK_DATA     <= '0;
      OK_READY    <= 1'b0;
      OK_LAST     <= 1'b0;
      OK_BYTE_NUM <= 3'd0;
      tmo_cnt     <= '0;
    end else begin
      OK_READY <= xfer;
      if (xfer) begin
        OK_DATA     <= IWDATA;
        OK_LAST     <= IWLAST;
        OK_BYTE_NUM <= IWLAST ? IWBYTES : 3'd0;
        if (OWORD_CNT != {CNT_W{1'b1}}) OWORD_CNT <= OWORD_CNT + CNT_W'(1);
      end
      if ((state == IDLE) && ISTART) begin
        ODONE     <= 1'b0;
        OERR      <= 1'b0;
        OWORD_CNT <= '0;
      end
      // Digest-ready is checked before expiry so a same-cycle arrival still completes cleanly.
      if (state == WAIT) begin
        if (IK_READY) begin
          ODIGEST <= IK_DATA;
          ODONE   <= 1'b1;
        end else if (tmo_hit) begin
          OERR <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/sha3_msg_ctrl.md
Name: sha3_msg_ctrl

Overview:
- Sequencer for the 64-bit-word Keccak/SHA3-512 core.
- Accepts a host word stream over a valid/ready handshake and starts each message with a clean core.
- Drives the core's data/ready/last/byte-count inputs, honouring its buffer-full back-pressure.
- Captures the 512-bit digest into a holding register, provides done/busy/error status and a hash-completion timeout.

Parameters:
- DATA_W, 64, word width toward the core.
- DIGEST_W, 512, digest width.
- CNT_W, 16, width of the absorbed-word counter.
- TIMEOUT, 4096, max cycles in WAIT before error.

Ports:
- ICLK  in  1  clock.
- IRST  in  1  synchronous reset, active-low.
- ISTART  in  1  one-cycle pulse; begin new message; ignored unless in IDLE.
- IWDATA  in  DATA_W  host message word.
- IWVALID  in  1  IWDATA valid.
- IWLAST  in  1  word is the final word of the message.
- IWBYTES  in  3  valid bytes in the last word (0..7); meaningful only with IWLAST.
- OWREADY  out  1  controller accepts a word this cycle.
- OBUSY  out  1  state != IDLE.
- ODONE  out  1  digest valid; sticky until next accepted ISTART.
- OERR  out  1  timeout occurred; sticky until next accepted ISTART.
- ODIGEST  out  DIGEST_W  captured digest.
- OWORD_CNT  out  CNT_W  words forwarded in the current message (saturating).
- OK_RST  out  1  core reset, asserted high.
- OK_DATA  out  DATA_W  to core data input.
- OK_READY  out  1  to core ready input.
- OK_LAST  out  1  to core last input.
- OK_BYTE_NUM  out  3  to core byte-count input.
- IK_BUFFER_FULL  in  1  from core buffer-full output.
- IK_DATA  in  DIGEST_W  from core digest output.
- IK_READY  in  1  from core digest-ready output.

Behaviour:
- Reset (IRST=0 at a clock edge):
  - State goes to IDLE.
  - All outputs are 0: OWREADY, OBUSY, ODONE, OERR, ODIGEST, OWORD_CNT, OK_*.
  - Reset takes priority over every other event, including mid-message. No partial digest is retained.
- FSM states: IDLE, CLR, ABSORB, WAIT.
- IDLE:
  - OWREADY=0; IWVALID is ignored.
  - ISTART=1 moves to CLR. On that edge: ODONE, OERR and OWORD_CNT are cleared; ODIGEST is held.
- CLR:
  - Lasts exactly one cycle with OK_RST=1, then moves to ABSORB.
- ABSORB:
  - OWREADY = !IK_BUFFER_FULL (combinational).
  - Transfer occurs when IWVALID && OWREADY.
  - On the edge after a transfer: OK_DATA=IWDATA, OK_READY=1, OK_LAST=IWLAST, OK_BYTE_NUM = IWLAST ? IWBYTES : 0. OWORD_CNT increments and saturates at all-ones.
  - OK_READY is high for exactly one cycle per transfer. Latency from transfer to core strobe is 1 cycle.
  - OK_DATA, OK_LAST and OK_BYTE_NUM hold their values when OK_READY=0.
  - If IK_BUFFER_FULL rises in the same cycle as IWVALID, no transfer occurs and the word must be held by the host.
  - A transfer with IWLAST=1 moves to WAIT.
- Message framing:
  - A full 8-byte final word is sent as a normal word followed by a last word with IWBYTES=0.
  - An empty message is a single last word with IWBYTES=0 (IWDATA ignored by the core).
- WAIT:
  - OWREADY=0.
  - When IK_READY=1: ODIGEST <= IK_DATA, ODONE <= 1, go to IDLE.
  - A cycle counter runs from entry. If TIMEOUT cycles elapse without IK_READY: OERR <= 1, ODIGEST unchanged, go to IDLE.
  - If IK_READY arrives on the same cycle the count expires, IK_READY wins (done, no error).
- Other rules:
  - ISTART outside IDLE is ignored; status and counters are unaffected.
  - IK_READY outside WAIT is ignored.
  - ISTART and IWVALID in the same IDLE cycle: the word is not accepted.

Test Plan:
- Reset mid-ABSORB (after 3 words) → next cycle all outputs 0, state IDLE; a following ISTART produces a 1-cycle OK_RST and OWORD_CNT=0.
- "abc" message: ISTART, then one last word IWDATA=64'h0000000000636261, IWBYTES=3 → OK_READY 1 cycle later with OK_LAST=1, OK_BYTE_NUM=3, OWORD_CNT=1. Model IK_READY with the SHA3-512("abc") digest → ODIGEST equals it, ODONE=1, OBUSY=0.
- 17 full words plus a last word with IWBYTES=0 while the core model raises IK_BUFFER_FULL for 5 cycles after word 9 → OWREADY=0 for exactly those cycles, no OK_READY pulses in that window, no word dropped or duplicated, OWORD_CNT=18.
- Empty message: single last word with IWBYTES=0 → exactly one OK_READY pulse with OK_LAST=1, OK_BYTE_NUM=0; ODONE after IK_READY.
- Timeout with TIMEOUT=16 and IK_READY never asserted → OERR=1 exactly 16 cycles after WAIT entry, ODIGEST unchanged, ODONE=0. With IK_READY on cycle 16 instead → ODONE=1, OERR=0.
- ISTART pulsed during ABSORB and WAIT → ignored: no OK_RST pulse, OWORD_CNT unchanged, message completes normally.
